// File: rtl/sdr_cfg_master.sv
// Configuration master for the SDRAM controller: register file for timing, mode and refresh
// settings, plus an enable sequencer that waits for controller init with a timeout.
module sdr_cfg_master #(
    parameter int unsigned SDR_REFRESH_TIMER_W   = 12,
    parameter int unsigned SDR_REFRESH_ROW_CNT_W = 3,
    parameter logic [15:0] INIT_TIMEOUT          = 16'd50000
) (
    input  logic                             sdram_clk,
    input  logic                             sdram_resetn,
    input  logic                             reg_req,
    input  logic                             reg_wr,
    input  logic [2:0]                       reg_addr,
    input  logic [31:0]                      reg_wdata,
    output logic [31:0]                      reg_rdata,
    output logic                             reg_ack,
    output logic [1:0]                       cfg_sdr_width,
    output logic [1:0]                       cfg_colbits,
    output logic [3:0]                       cfg_sdr_tras_d,
    output logic [3:0]                       cfg_sdr_trp_d,
    output logic [3:0]                       cfg_sdr_trcd_d,
    output logic                             cfg_sdr_en,
    output logic [1:0]                       cfg_req_depth,
    output logic [12:0]                      cfg_sdr_mode_reg,
    output logic [2:0]                       cfg_sdr_cas,
    output logic [3:0]                       cfg_sdr_trcar_d,
    output logic [3:0]                       cfg_sdr_twr_d,
    output logic [SDR_REFRESH_TIMER_W-1:0]   cfg_sdr_rfsh,
    output logic [SDR_REFRESH_ROW_CNT_W-1:0] cfg_sdr_rfmax,
    input  logic                             sdr_init_done
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENABLING = 2'd1,
        ST_READY    = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam logic [SDR_REFRESH_TIMER_W-1:0]   RFSH_RST  = SDR_REFRESH_TIMER_W'(32'h100);
    localparam logic [SDR_REFRESH_ROW_CNT_W-1:0] RFMAX_RST = SDR_REFRESH_ROW_CNT_W'(32'd4);
    localparam logic [15:0]                      CNT_LOAD  = INIT_TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic        en_q, en_d;
    logic        wr_err_q, wr_err_d;
    logic        tout_q, tout_d;

    logic [3:0]  tras_q, tras_d, trp_q, trp_d, trcd_q, trcd_d;
    logic [3:0]  trcar_q, trcar_d, twr_q, twr_d;
    logic [2:0]  cas_q, cas_d;
    logic [12:0] mode_q, mode_d;
    logic [1:0]  width_q, width_d, colbits_q, colbits_d, depth_q, depth_d;
    logic [SDR_REFRESH_TIMER_W-1:0]   rfsh_q, rfsh_d;
    logic [SDR_REFRESH_ROW_CNT_W-1:0] rfmax_q, rfmax_d;

    logic acc, wr_acc, wr_cfg, cfg_open, cfg_upd, wr_err_set, tout_set;
    logic cmd_start, cmd_stop, clr_status;
    logic unused_wdata;

    assign acc        = reg_req & ~ack_q;
    assign wr_acc     = acc & reg_wr;
    assign wr_cfg     = wr_acc & (reg_addr <= 3'd2);
    assign cfg_open   = (state_q == ST_DISABLED) || (state_q == ST_ERROR);
    assign cfg_upd    = wr_cfg & cfg_open;
    assign wr_err_set = wr_cfg & ~cfg_open;
    // STOP dominates when both control bits are written together
    assign cmd_stop   = wr_acc & (reg_addr == 3'd3) & reg_wdata[1];
    assign cmd_start  = wr_acc & (reg_addr == 3'd3) & reg_wdata[0] & ~reg_wdata[1];
    assign clr_status = wr_acc & (reg_addr == 3'd4);
    assign unused_wdata = ^reg_wdata;

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            state_q <= ST_DISABLED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tout_set = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                if (cmd_start) begin
                    state_d = ST_ENABLING;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_ENABLING: begin
                if (cmd_stop) begin
                    state_d = ST_DISABLED;
                end else if (sdr_init_done) begin
                    state_d = ST_READY;
                end else if (cnt_q == 16'd0) begin
                    state_d  = ST_ERROR;
                    tout_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_READY: begin
                if (cmd_stop) begin
                    state_d = ST_DISABLED;
                end else if (!sdr_init_done) begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                if (cmd_stop) begin
                    state_d = ST_DISABLED;
                end else if (cmd_start) begin
                    state_d = ST_ENABLING;
                    cnt_d   = CNT_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (reg_addr)
            3'd0: rd_val = {9'd0, cas_q, twr_q, trcar_q, trcd_q, trp_q, tras_q};
            3'd1: rd_val = {10'd0, depth_q, colbits_q, width_q, 3'd0, mode_q};
            3'd2: begin
                rd_val[SDR_REFRESH_TIMER_W-1:0]      = rfsh_q;
                rd_val[16 +: SDR_REFRESH_ROW_CNT_W]  = rfmax_q;
            end
            3'd4: rd_val = {27'd0, tout_q, wr_err_q, sdr_init_done, 2'(state_q)};
            default: rd_val = '0;
        endcase
        rdata_d  = (acc && !reg_wr) ? rd_val : '0;
        ack_d    = acc;
        en_d     = (state_d == ST_ENABLING) || (state_d == ST_READY);
        // a same-cycle set beats the write-1-to-clear
        wr_err_d = (wr_err_q & ~(clr_status & reg_wdata[3])) | wr_err_set;
        tout_d   = (tout_q & ~(clr_status & reg_wdata[4])) | tout_set;
    end

    always_comb begin
        tras_d    = tras_q;
        trp_d     = trp_q;
        trcd_d    = trcd_q;
        trcar_d   = trcar_q;
        twr_d     = twr_q;
        cas_d     = cas_q;
        mode_d    = mode_q;
        width_d   = width_q;
        colbits_d = colbits_q;
        depth_d   = depth_q;
        rfsh_d    = rfsh_q;
        rfmax_d   = rfmax_q;
        if (cfg_upd) begin
            case (reg_addr)
                3'd0: begin
                    tras_d  = reg_wdata[3:0];
                    trp_d   = reg_wdata[7:4];
                    trcd_d  = reg_wdata[11:8];
                    trcar_d = reg_wdata[15:12];
                    twr_d   = reg_wdata[19:16];
                    cas_d   = reg_wdata[22:20];
                end
                3'd1: begin
                    mode_d    = reg_wdata[12:0];
                    width_d   = reg_wdata[17:16];
                    colbits_d = reg_wdata[19:18];
                    depth_d   = reg_wdata[21:20];
                end
                default: begin
                    rfsh_d  = reg_wdata[SDR_REFRESH_TIMER_W-1:0];
                    rfmax_d = reg_wdata[16 +: SDR_REFRESH_ROW_CNT_W];
                end
            endcase
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            wr_err_q  <= 1'b0;
            tout_q    <= 1'b0;
            tras_q    <= 4'd4;
            trp_q     <= 4'd2;
            trcd_q    <= 4'd2;
            trcar_q   <= 4'd7;
            twr_q     <= 4'd1;
            cas_q     <= 3'd3;
            mode_q    <= 13'h033;
            width_q   <= 2'b01;
            colbits_q <= 2'b00;
            depth_q   <= 2'b11;
            rfsh_q    <= RFSH_RST;
            rfmax_q   <= RFMAX_RST;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            wr_err_q  <= wr_err_d;
            tout_q    <= tout_d;
            tras_q    <= tras_d;
            trp_q     <= trp_d;
            trcd_q    <= trcd_d;
            trcar_q   <= trcar_d;
            twr_q     <= twr_d;
            cas_q     <= cas_d;
            mode_q    <= mode_d;
            width_q   <= width_d;
            colbits_q <= colbits_d;
            depth_q   <= depth_d;
            rfsh_q    <= rfsh_d;
            rfmax_q   <= rfmax_d;
        end
    end

    assign reg_ack          = ack_q;
    assign reg_rdata        = rdata_q;
    assign cfg_sdr_en       = en_q;
    assign cfg_sdr_tras_d   = tras_q;
    assign cfg_sdr_trp_d    = trp_q;
    assign cfg_sdr_trcd_d   = trcd_q;
    assign cfg_sdr_trcar_d  = trcar_q;
    assign cfg_sdr_twr_d    = twr_q;
    assign cfg_sdr_cas      = cas_q;
    assign cfg_sdr_mode_reg = mode_q;
    assign cfg_sdr_width    = width_q;
    assign cfg_colbits      = colbits_q;
    assign cfg_req_depth    = depth_q;
    assign cfg_sdr_rfsh     = rfsh_q;
    assign cfg_sdr_rfmax    = rfmax_q;

endmodule

// File: tb/tb_sdr_cfg_master.sv
// Scoreboard bench for sdr_cfg_master: a cycle reference model predicts acks, read data and
// configuration outputs; a second instance with a short init timeout covers the timeout path.
module tb_sdr_cfg_master;

    localparam int TO = 16;

    int n_checks = 0;
    int n_err    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, req, wr, init_done;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack, en;
    logic [1:0]  width, colbits, depth;
    logic [3:0]  tras, trp, trcd, trcar, twr;
    logic [12:0] mode;
    logic [2:0]  cas;
    logic [11:0] rfsh;
    logic [2:0]  rfmax;

    sdr_cfg_master #(
        .SDR_REFRESH_TIMER_W(12),
        .SDR_REFRESH_ROW_CNT_W(3),
        .INIT_TIMEOUT(16'(TO))
    ) dut (
        .sdram_clk(clk), .sdram_resetn(rstn), .reg_req(req), .reg_wr(wr), .reg_addr(addr),
        .reg_wdata(wdata), .reg_rdata(rdata), .reg_ack(ack), .cfg_sdr_width(width),
        .cfg_colbits(colbits), .cfg_sdr_tras_d(tras), .cfg_sdr_trp_d(trp), .cfg_sdr_trcd_d(trcd),
        .cfg_sdr_en(en), .cfg_req_depth(depth), .cfg_sdr_mode_reg(mode), .cfg_sdr_cas(cas),
        .cfg_sdr_trcar_d(trcar), .cfg_sdr_twr_d(twr), .cfg_sdr_rfsh(rfsh), .cfg_sdr_rfmax(rfmax),
        .sdr_init_done(init_done)
    );

    // second instance with an 8-cycle init timeout
    logic        t_rstn, t_req, t_wr, t_done;
    logic [2:0]  t_addr;
    logic [31:0] t_wdata, t_rdata;
    logic        t_ack, t_en;
    logic [1:0]  t_width, t_colbits, t_depth;
    logic [3:0]  t_tras, t_trp, t_trcd, t_trcar, t_twr;
    logic [12:0] t_mode;
    logic [2:0]  t_cas;
    logic [11:0] t_rfsh;
    logic [2:0]  t_rfmax;

    sdr_cfg_master #(
        .SDR_REFRESH_TIMER_W(12),
        .SDR_REFRESH_ROW_CNT_W(3),
        .INIT_TIMEOUT(16'd8)
    ) u_to (
        .sdram_clk(clk), .sdram_resetn(t_rstn), .reg_req(t_req), .reg_wr(t_wr), .reg_addr(t_addr),
        .reg_wdata(t_wdata), .reg_rdata(t_rdata), .reg_ack(t_ack), .cfg_sdr_width(t_width),
        .cfg_colbits(t_colbits), .cfg_sdr_tras_d(t_tras), .cfg_sdr_trp_d(t_trp),
        .cfg_sdr_trcd_d(t_trcd), .cfg_sdr_en(t_en), .cfg_req_depth(t_depth),
        .cfg_sdr_mode_reg(t_mode), .cfg_sdr_cas(t_cas), .cfg_sdr_trcar_d(t_trcar),
        .cfg_sdr_twr_d(t_twr), .cfg_sdr_rfsh(t_rfsh), .cfg_sdr_rfmax(t_rfmax),
        .sdr_init_done(t_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_read;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          m_state;     // 0 disabled, 1 enabling, 2 ready, 3 error
    int          m_elapsed;   // edges spent waiting for init in ENABLING
    bit          m_ack, m_wrerr, m_tout;
    logic [31:0] m_word[3];
    bit          mon_en = 1'b0;

    function automatic logic [31:0] wmask(input int a);
        case (a)
            0:       return 32'h007F_FFFF;
            1:       return 32'h003F_1FFF;
            default: return 32'h0007_0FFF;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a, input logic done);
        if (a <= 3'd2) return m_word[a];
        if (a == 3'd4) return {27'd0, m_tout, m_wrerr, done, 2'(m_state)};
        return 32'd0;
    endfunction

    function automatic logic [63:0] exp_cfg();
        logic [31:0] w0, w1, w2;
        w0 = m_word[0];
        w1 = m_word[1];
        w2 = m_word[2];
        return {7'd0, w0[3:0], w0[7:4], w0[11:8], w0[15:12], w0[19:16], w0[22:20],
                w1[12:0], w1[17:16], w1[19:18], w1[21:20], w2[11:0], w2[18:16]};
    endfunction

    always @(posedge clk) begin : model
        bit   acc, wrx, start, stop, set_err, set_to, clr;
        exp_t e;
        int   nxt;
        if (!rstn) begin
            m_state   = 0;
            m_elapsed = 0;
            m_ack     = 0;
            m_wrerr   = 0;
            m_tout    = 0;
            m_word[0] = 32'h0031_7224;
            m_word[1] = 32'h0031_0033;
            m_word[2] = 32'h0004_0100;
            sb.delete();
        end else begin
            acc     = req && !m_ack;
            wrx     = acc && wr;
            stop    = wrx && addr == 3'd3 && wdata[1];
            start   = wrx && addr == 3'd3 && wdata[0] && !wdata[1];
            clr     = wrx && addr == 3'd4;
            set_err = 0;
            set_to  = 0;
            if (acc) begin
                e.is_read = !wr;
                e.val     = wr ? 32'd0 : m_read(addr, init_done);
                sb.push_back(e);
            end
            if (wrx && addr <= 3'd2) begin
                if (m_state == 0 || m_state == 3) m_word[addr] = wdata & wmask(int'(addr));
                else set_err = 1;
            end
            nxt = m_state;
            case (m_state)
                0: if (start) begin nxt = 1; m_elapsed = 0; end
                1: begin
                    if (stop) nxt = 0;
                    else if (init_done) nxt = 2;
                    else if (m_elapsed == TO - 1) begin nxt = 3; set_to = 1; end
                    else m_elapsed++;
                end
                2: if (stop) nxt = 0; else if (!init_done) nxt = 3;
                default: begin
                    if (stop) nxt = 0;
                    else if (start) begin nxt = 1; m_elapsed = 0; end
                end
            endcase
            m_state = nxt;
            m_wrerr = (m_wrerr && !(clr && wdata[3])) || set_err;
            m_tout  = (m_tout && !(clr && wdata[4])) || set_to;
            m_ack   = acc;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            chk("ack", ack, m_ack);
            if (ack) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_read) chk("rdata", rdata, e.val);
                end
            end else begin
                chk("rdata_idle", rdata, 0);
            end
            chk("cfg_fields", {7'd0, tras, trp, trcd, trcar, twr, cas, mode, width, colbits, depth,
                               rfsh, rfmax}, exp_cfg());
            chk("cfg_sdr_en", en, (m_state == 1 || m_state == 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input bit w, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        req   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        access(1'b0, a, 32'd0);
        chk(name, rdata, exp);
    endtask

    task automatic t_access(input bit w, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        t_req   = 1'b1;
        t_wr    = w;
        t_addr  = a;
        t_wdata = d;
        @(negedge clk);
        t_req   = 1'b0;
    endtask

    initial begin
        int k;
        rstn = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; init_done = 1'b0;
        t_rstn = 1'b0; t_req = 1'b0; t_wr = 1'b0; t_addr = '0; t_wdata = '0; t_done = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        t_rstn = 1'b1;

        rd_chk("rst_timing", 3'd0, 32'h0031_7224);
        rd_chk("rst_mode", 3'd1, 32'h0031_0033);
        rd_chk("rst_refresh", 3'd2, 32'h0004_0100);
        rd_chk("rst_status", 3'd4, 32'h0);
        rd_chk("ctrl_reads0", 3'd3, 32'h0);
        rd_chk("unmapped_reads0", 3'd6, 32'h0);

        // write timing while disabled, start, init completes 10 cycles later
        access(1'b1, 3'd0, 32'h0022_1333);
        access(1'b1, 3'd3, 32'h1);
        chk("en_with_ctrl_ack", en, 1);
        repeat (9) @(negedge clk);
        init_done = 1'b1;
        repeat (2) @(negedge clk);
        rd_chk("status_ready", 3'd4, 32'h6);
        chk("tras_written", tras, 4'd3);

        // config write in READY is discarded and flagged
        access(1'b1, 3'd0, 32'h0);
        chk("tras_kept", tras, 4'd3);
        rd_chk("status_wrerr", 3'd4, 32'hE);
        access(1'b1, 3'd4, 32'h8);
        rd_chk("status_wrerr_clr", 3'd4, 32'h6);

        // init_done falls in READY
        init_done = 1'b0;
        @(negedge clk);
        chk("en_after_drop", en, 0);
        rd_chk("status_error", 3'd4, 32'h3);

        // restart then STOP+START together while enabling
        access(1'b1, 3'd3, 32'h1);
        access(1'b1, 3'd3, 32'h3);
        chk("en_after_stop", en, 0);
        rd_chk("status_stopped", 3'd4, 32'h0);

        // reach READY, then reset with a read ack pending
        init_done = 1'b1;
        access(1'b1, 3'd3, 32'h1);
        repeat (2) @(negedge clk);
        rd_chk("status_ready2", 3'd4, 32'h6);
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 3'd0;
        @(negedge clk);
        req = 1'b0; rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_en", en, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_tras", tras, 4'd4);
        chk("rst_cas", cas, 3'd3);
        chk("rst_rfsh", rfsh, 12'h100);

        // timeout on the short-timeout instance
        t_access(1'b1, 3'd3, 32'h1);
        chk("to_en_start", t_en, 1);
        k = 0;
        while (t_en && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", k, 8);
        t_access(1'b0, 3'd4, 32'h0);
        chk("to_status", t_rdata, 32'h13);
        t_access(1'b1, 3'd4, 32'h10);
        t_access(1'b0, 3'd4, 32'h0);
        chk("to_status_clr", t_rdata, 32'h3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) init_done = ~init_done;
            req  = $urandom_range(0, 1);
            wr   = $urandom_range(0, 1);
            addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) addr = 3'd3;
            wdata = $urandom;
            if (addr == 3'd3 && $urandom_range(0, 3) != 0) wdata = 32'($urandom_range(0, 3));
        end
        @(negedge clk);
        rstn = 1'b1;
        req  = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
